// File: rtl/ifu_pkg.sv
// ============================================================================
// Module : ifu_pkg
// Brief  : Shared types and constants for the RV32 instruction fetch unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

   localparam int unsigned XLEN             = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_BUS_ERR  = 2'd1,
      CAUSE_MISALIGN = 2'd2,
      CAUSE_TIMEOUT  = 2'd3
   } fault_cause_t;

endpackage

`default_nettype wire

// File: rtl/ifu_if.sv
// ============================================================================
// Module : ifu_if
// Brief  : Instruction-memory request/response bus (master = fetch unit).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifu_if;
   import ifu_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            imem_rsp_err;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
   );
endinterface

`default_nettype wire

// File: rtl/ifu_watchdog.sv
// ============================================================================
// Module : ifu_watchdog
// Brief  : WAIT-cycle counter with terminal-count flag (used with IFU_TIMEOUT_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_watchdog #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  wire clk,
   input  wire rstn,
   input  wire clear,
   input  wire active,
   output logic expired
);
   localparam int unsigned     CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt;

   // cnt holds the index of the current WAIT cycle; it saturates at LAST
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         cnt <= '0;
      end else if (active && cnt != LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = active && (cnt == LAST);
endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module : ifu_fetch
// Brief  : RV32 fetch unit: PC, REQ/WAIT/HOLD/HALT FSM, retire counter.
//          Optional WAIT timeout enabled by macro IFU_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  wire             clk,
   input  wire             rstn,
   ifu_if.master           imem,
   output logic            inst_valid,
   input  wire             inst_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] mem_inst_out,
   input  wire             redirect_valid,
   input  wire [XLEN-1:0]  redirect_pc,
   input  wire             halt,
   output logic            fetch_fault,
   output logic [1:0]      fault_cause,
   output logic [63:0]     inst_count
);
   state_t          state, state_next;
   logic [XLEN-1:0] pc, pc_next;
   logic [XLEN-1:0] inst, inst_next;
   logic            fault, fault_next;
   fault_cause_t    cause, cause_next;
   logic [63:0]     count, count_next;
   logic            timeout;

`ifdef IFU_TIMEOUT_EN
   ifu_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (state == ST_REQ && imem.imem_req_ready),
      .active  (state == ST_WAIT),
      .expired (timeout)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= ST_REQ;
         pc    <= RESET_PC;
         inst  <= '0;
         fault <= 1'b0;
         cause <= CAUSE_NONE;
         count <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         inst  <= inst_next;
         fault <= fault_next;
         cause <= cause_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      inst_next  = inst;
      fault_next = fault;
      cause_next = cause;
      count_next = count;
      unique case (state)
         ST_REQ: begin
            if (imem.imem_req_ready) state_next = ST_WAIT;
         end
         ST_WAIT: begin
            // a response in the terminal-count cycle takes precedence over the timeout
            if (imem.imem_rsp_valid) begin
               if (imem.imem_rsp_err) begin
                  fault_next = 1'b1;
                  cause_next = CAUSE_BUS_ERR;
                  state_next = ST_HALT;
               end else begin
                  inst_next  = imem.imem_rsp_data;
                  state_next = ST_HOLD;
               end
            end else if (timeout) begin
               fault_next = 1'b1;
               cause_next = CAUSE_TIMEOUT;
               state_next = ST_HALT;
            end
         end
         ST_HOLD: begin
            if (inst_ready) begin
               count_next = count + 64'd1;
               if (halt) begin
                  state_next = ST_HALT;
               end else if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
                  fault_next = 1'b1;
                  cause_next = CAUSE_MISALIGN;
                  state_next = ST_HALT;
               end else begin
                  pc_next    = redirect_valid ? redirect_pc : pc + 32'd4;
                  state_next = ST_REQ;
               end
            end
         end
         ST_HALT: begin
         end
      endcase
   end

   assign imem.imem_req_valid = (state == ST_REQ);
   assign imem.imem_req_addr  = pc;
   assign inst_valid          = (state == ST_HOLD);
   assign pc_out              = pc;
   assign mem_inst_out        = inst;
   assign fetch_fault         = fault;
   assign fault_cause         = cause;
   assign inst_count          = count;
endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module : tb_ifu_fetch
// Brief  : Scoreboard bench for ifu_fetch with a behavioural instruction memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;
   typedef struct {
      logic        hlt;
      logic        redir;
      logic [31:0] rpc;
   } act_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        inst_valid;
   logic        inst_ready = 1'b1;
   logic [31:0] pc_out;
   logic [31:0] mem_inst_out;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic        fetch_fault;
   logic [1:0]  fault_cause;
   logic [63:0] inst_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] exp_req[$];
   logic [31:0] exp_pc[$];
   logic [31:0] exp_dat[$];
   act_t        act_q[$];

   // memory model settings
   int          stall_left = 0;
   int          rsp_delay = 0;
   logic        err_next = 1'b0;
   logic        noise = 1'b0;
   logic [31:0] halt_word_addr = 32'h0000_0002;
   logic        hs_seen = 1'b0;
   logic [31:0] hs_addr = '0;
   logic        pend = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;

   ifu_if imem_bus ();

   ifu_fetch #(.RESET_PC(32'h8000_0000), .TIMEOUT_CYC(8)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .imem           (imem_bus.master),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .pc_out         (pc_out),
      .mem_inst_out   (mem_inst_out),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .fetch_fault    (fetch_fault),
      .fault_cause    (fault_cause),
      .inst_count     (inst_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == halt_word_addr) return 32'h0010_0073;
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic exp_fetch(input logic [31:0] a, input logic h, input logic r, input logic [31:0] rpc);
      act_t t;
      t.hlt = h; t.redir = r; t.rpc = rpc;
      exp_req.push_back(a);
      exp_pc.push_back(a);
      exp_dat.push_back(mem_word(a));
      act_q.push_back(t);
   endtask

   // instruction memory: accepts requests after stall_left cycles, answers after rsp_delay WAIT cycles
   initial begin
      imem_bus.imem_req_ready = 1'b0;
      imem_bus.imem_rsp_valid = 1'b0;
      imem_bus.imem_rsp_data  = '0;
      imem_bus.imem_rsp_err   = 1'b0;
      forever begin
         @(posedge clk); #2;
         imem_bus.imem_rsp_valid = 1'b0;
         imem_bus.imem_rsp_err   = 1'b0;
         imem_bus.imem_rsp_data  = '0;
         if (hs_seen) begin
            hs_seen = 1'b0; pend = 1'b1; pend_cnt = rsp_delay; pend_addr = hs_addr;
         end
         if (pend && pend_cnt == 0) begin
            imem_bus.imem_rsp_valid = 1'b1;
            imem_bus.imem_rsp_data  = mem_word(pend_addr);
            imem_bus.imem_rsp_err   = err_next;
            pend = 1'b0;
         end else if (pend && pend_cnt > 0) begin
            pend_cnt--;
         end else if (!pend && noise) begin
            imem_bus.imem_rsp_valid = 1'b1;
            imem_bus.imem_rsp_err   = 1'b1;
            imem_bus.imem_rsp_data  = 32'hDEAD_BEEF;
         end
         imem_bus.imem_req_ready = (stall_left == 0);
         if (stall_left > 0 && rstn && imem_bus.imem_req_valid) stall_left--;
      end
   end

   // downstream: applies the scripted action while an instruction is held, noise otherwise
   initial begin
      forever begin
         @(posedge clk); #1;
         if (inst_valid && act_q.size() > 0) begin
            redirect_valid = act_q[0].redir;
            redirect_pc    = act_q[0].rpc;
            halt           = act_q[0].hlt;
         end else if (noise) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h1234_5673;
            halt           = 1'b1;
         end else begin
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            halt           = 1'b0;
         end
      end
   end

   // monitor: pops expectations on request handshakes and retires
   always @(negedge clk) begin
      if (rstn) begin
         if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
            hs_seen = 1'b1;
            hs_addr = imem_bus.imem_req_addr;
            if (exp_req.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_req: got addr %h expected no request", imem_bus.imem_req_addr);
            end else begin
               chk("req_addr", {32'h0, imem_bus.imem_req_addr}, {32'h0, exp_req.pop_front()});
            end
         end
         if (inst_valid && inst_ready) begin
            if (act_q.size() > 0) void'(act_q.pop_front());
            if (exp_pc.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_retire: got pc %h expected no retire", pc_out);
            end else begin
               chk("ret_pc", {32'h0, pc_out}, {32'h0, exp_pc.pop_front()});
               chk("ret_inst", {32'h0, mem_inst_out}, {32'h0, exp_dat.pop_front()});
            end
         end
      end
   end

   task automatic do_reset(input int cycles, input int stall);
      chk("drain", 64'(exp_req.size() + exp_pc.size()), 64'd0);
      rstn = 1'b0;
      exp_req.delete(); exp_pc.delete(); exp_dat.delete(); act_q.delete();
      hs_seen = 1'b0; pend = 1'b0; noise = 1'b0; rsp_delay = 0; err_next = 1'b0;
      halt_word_addr = 32'h0000_0002;
      stall_left = stall;
      repeat (cycles) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic wait_count(input logic [63:0] v, input int budget, output int n);
      n = 0;
      while (inst_count !== v && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      chk("inst_count", inst_count, v);
   endtask

   initial begin
      int n;
      #400000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      // 1: reset state, sequential fetch, 3-cycle cadence
      do_reset(2, 0);
      chk("rst_inst_valid", {63'h0, inst_valid}, 64'd0);
      chk("rst_fault", {63'h0, fetch_fault}, 64'd0);
      chk("rst_cause", {62'h0, fault_cause}, 64'd0);
      chk("rst_count", inst_count, 64'd0);
      chk("rst_pc", {32'h0, pc_out}, 64'h8000_0000);
      chk("rst_inst", {32'h0, mem_inst_out}, 64'd0);
      chk("rst_req_valid", {63'h0, imem_bus.imem_req_valid}, 64'd1);
      exp_fetch(32'h8000_0000, 1'b0, 1'b0, '0);
      exp_fetch(32'h8000_0004, 1'b0, 1'b0, '0);
      exp_fetch(32'h8000_0008, 1'b1, 1'b0, '0);
      wait_count(64'd3, 60, n);
      chk("t1_cycles", 64'(n), 64'd10);

      // 2: ebreak-style halt freezes the unit
      do_reset(2, 0);
      halt_word_addr = 32'h8000_0000;
      exp_fetch(32'h8000_0000, 1'b1, 1'b0, '0);
      wait_count(64'd1, 30, n);
      repeat (5) @(negedge clk);
      chk("t2_req_valid", {63'h0, imem_bus.imem_req_valid}, 64'd0);
      chk("t2_inst_valid", {63'h0, inst_valid}, 64'd0);
      chk("t2_count", inst_count, 64'd1);
      chk("t2_inst", {32'h0, mem_inst_out}, 64'h0010_0073);

      // 3: redirects, PC wrap, noise on redirect/halt/rsp outside their windows
      do_reset(2, 0);
      noise = 1'b1;
      exp_fetch(32'h8000_0000, 1'b0, 1'b1, 32'h8000_0100);
      exp_fetch(32'h8000_0100, 1'b0, 1'b1, 32'hFFFF_FFFC);
      exp_fetch(32'hFFFF_FFFC, 1'b0, 1'b0, '0);
      exp_fetch(32'h0000_0000, 1'b1, 1'b0, '0);
      wait_count(64'd4, 80, n);
      repeat (4) @(negedge clk);
      chk("t3_fault", {63'h0, fetch_fault}, 64'd0);
      chk("t3_req_valid", {63'h0, imem_bus.imem_req_valid}, 64'd0);

      // 4: misaligned redirect faults; single-cycle reset recovers
      do_reset(2, 0);
      exp_fetch(32'h8000_0000, 1'b0, 1'b1, 32'h8000_0102);
      wait_count(64'd1, 30, n);
      repeat (3) @(negedge clk);
      chk("t4_fault", {63'h0, fetch_fault}, 64'd1);
      chk("t4_cause", {62'h0, fault_cause}, 64'd2);
      chk("t4_inst_valid", {63'h0, inst_valid}, 64'd0);
      chk("t4_req_valid", {63'h0, imem_bus.imem_req_valid}, 64'd0);
      do_reset(1, 0);
      chk("t4_fault_clr", {63'h0, fetch_fault}, 64'd0);
      exp_fetch(32'h8000_0000, 1'b1, 1'b0, '0);
      wait_count(64'd1, 30, n);

      // 5: request stall keeps addr/valid stable; bus error faults
      do_reset(2, 5);
      exp_req.push_back(32'h8000_0000);
      err_next = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_stall_valid", {63'h0, imem_bus.imem_req_valid}, 64'd1);
         chk("t5_stall_addr", {32'h0, imem_bus.imem_req_addr}, 64'h8000_0000);
      end
      n = 0;
      while (!fetch_fault && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t5_fault", {63'h0, fetch_fault}, 64'd1);
      chk("t5_cause", {62'h0, fault_cause}, 64'd1);
      repeat (3) @(negedge clk);
      chk("t5_inst_valid", {63'h0, inst_valid}, 64'd0);
      chk("t5_count", inst_count, 64'd0);

`ifdef IFU_TIMEOUT_EN
      // 6: WAIT timeout after 8 cycles; a response on the 8th cycle wins
      do_reset(2, 0);
      rsp_delay = -1;
      exp_req.push_back(32'h8000_0000);
      repeat (9) @(negedge clk);
      chk("t6_no_fault_yet", {63'h0, fetch_fault}, 64'd0);
      @(negedge clk);
      chk("t6_fault", {63'h0, fetch_fault}, 64'd1);
      chk("t6_cause", {62'h0, fault_cause}, 64'd3);
      do_reset(2, 0);
      rsp_delay = 7;
      exp_fetch(32'h8000_0000, 1'b1, 1'b0, '0);
      wait_count(64'd1, 40, n);
      chk("t6_rsp_wins", {63'h0, fetch_fault}, 64'd0);
`endif

      chk("final_drain", 64'(exp_req.size() + exp_pc.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
